// File: rtl/adder_pkg.sv
// Shared types for the Brent-Kung adder datapath: PG word layout, buffer
// states and the per-bit propagate/generate rule.
package adder_pkg;

  localparam int ADDER_WIDTH = 32;

  typedef struct packed {
    logic [ADDER_WIDTH:0] p;
    logic [ADDER_WIDTH:0] g;
  } pg_word_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  // Subtraction folds into addition by inverting B and the carry-in; slot 0 carries c0.
  function automatic pg_word_t pg_compute(input logic [ADDER_WIDTH-1:0] a,
                                          input logic [ADDER_WIDTH-1:0] b,
                                          input logic                   cin,
                                          input logic                   sub);
    logic [ADDER_WIDTH-1:0] b_eff;
    pg_word_t               w;
    b_eff = b ^ {ADDER_WIDTH{sub}};
    w.p   = {a ^ b_eff, 1'b0};
    w.g   = {a & b_eff, (sub ? ~cin : cin)};
    return w;
  endfunction

endpackage

// File: rtl/pg_skid_buf.sv
// Two-entry skid buffer for PG words: full throughput with a registered
// in_ready, beats kept in arrival order.
module pg_skid_buf
  import adder_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  output logic     in_ready,
  input  pg_word_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output pg_word_t out_data
);

  buf_state_e state_q, state_d;
  pg_word_t   main_q, main_d;
  pg_word_t   skid_q, skid_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       accept_s;
  logic       pop_s;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    accept_s = in_valid & in_ready_q;
    pop_s    = out_valid_q & out_ready;
    case (state_q)
      EMPTY: begin
        if (accept_s) begin
          main_d  = in_data;
          state_d = ONE;
        end else begin
          state_d = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && pop_s) begin
          main_d  = in_data;
          state_d = ONE;
        end else if (accept_s) begin
          skid_d  = in_data;
          state_d = TWO;
        end else if (pop_s) begin
          state_d = EMPTY;
        end else begin
          state_d = ONE;
        end
      end
      TWO: begin
        // in_ready is low here, so only a pop can move the buffer.
        if (pop_s) begin
          main_d  = skid_q;
          state_d = ONE;
        end else begin
          state_d = TWO;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= pg_word_t'(0);
      skid_q      <= pg_word_t'(0);
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: rtl/pg_gen_stage.sv
// Registered operand front end of the Brent-Kung adder: turns operand beats
// into per-bit propagate/generate vectors with index 0 holding the carry-in.
module pg_gen_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_p,
  output logic [WIDTH:0]   out_g
);

  pg_word_t pg_in_s;
  pg_word_t pg_out_s;

  assign pg_in_s = pg_compute(in_a, in_b, in_cin, in_sub);

  pg_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pg_in_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pg_out_s)
  );

  assign out_p = pg_out_s.p;
  assign out_g = pg_out_s.g;

endmodule

// File: tb/tb_pg_gen_stage.sv
// Randomized bench for pg_gen_stage against a queue-based reference model
// that also reconstructs the arithmetic sum from the emitted P/G vectors.
module tb_pg_gen_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_p;
  logic [32:0] out_g;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
  } beat_t;

  beat_t mq[$];
  int    n_cmp = 0;
  int    n_err = 0;

  pg_gen_stage #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_g     (out_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Ripple the carries through the DUT's P/G to get {carry_out, sum}.
  function automatic logic [32:0] pg_sum(input logic [32:0] p, input logic [32:0] g);
    logic        c;
    logic [31:0] s;
    c = g[0];
    for (int i = 1; i <= 32; i++) begin
      s[i-1] = p[i] ^ c;
      c      = g[i] | (p[i] & c);
    end
    return {c, s};
  endfunction

  function automatic logic [32:0] arith(input beat_t e);
    logic [32:0] d;
    if (e.sub) begin
      d = {1'b0, e.a} - {1'b0, e.b} - {32'd0, e.cin};
      return {~d[32], d[31:0]};
    end
    return {1'b0, e.a} + {1'b0, e.b} + {32'd0, e.cin};
  endfunction

  task automatic check_model();
    beat_t       e;
    logic [31:0] bp;
    logic [32:0] ep, eg;
    chk("in_ready", {63'd0, in_ready}, {63'd0, (mq.size() < 2)});
    chk("out_valid", {63'd0, out_valid}, {63'd0, (mq.size() > 0)});
    if (mq.size() > 0) begin
      e  = mq[0];
      bp = e.sub ? ~e.b : e.b;
      ep = {e.a ^ bp, 1'b0};
      eg = {e.a & bp, (e.sub ? ~e.cin : e.cin)};
      chk("out_p", {31'd0, out_p}, {31'd0, ep});
      chk("out_g", {31'd0, out_g}, {31'd0, eg});
      chk("sum", {31'd0, pg_sum(out_p, out_g)}, {31'd0, arith(e)});
    end
  endtask

  task automatic step();
    logic acc, pop;
    acc = in_valid & (mq.size() < 2) & ~rst;
    pop = (mq.size() > 0) & out_ready & ~rst;
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back('{in_a, in_b, in_cin, in_sub});
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub, input logic ordy);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_sub    = sub;
    out_ready = ordy;
  endtask

  task automatic drive_rand(input logic v, input logic ordy);
    drive(v, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ordy);
  endtask

  logic [32:0] exp_v;
  logic        z_taken;

  initial begin
    rst = 1'b1;
    drive(1'b1, 32'h1234_5678, 32'h9abc_def0, 1'b1, 1'b0, 1'b1);
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_p", {31'd0, out_p}, 64'd0);
    chk("rst_out_g", {31'd0, out_g}, 64'd0);

    // Directed vectors, each visible the cycle after its accept.
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    step();
    exp_v = {32'hFFFF_FFFE, 1'b0};
    chk("add_p", {31'd0, out_p}, {31'd0, exp_v});
    exp_v = {32'h0000_0001, 1'b0};
    chk("add_g", {31'd0, out_g}, {31'd0, exp_v});

    drive(1'b1, 32'd5, 32'd3, 1'b0, 1'b1, 1'b1);
    step();
    exp_v = {32'hFFFF_FFF9, 1'b0};
    chk("sub_p", {31'd0, out_p}, {31'd0, exp_v});
    exp_v = {32'h0000_0004, 1'b1};
    chk("sub_g", {31'd0, out_g}, {31'd0, exp_v});
    chk("sub_valid", {63'd0, out_valid}, 64'd1);

    drive(1'b1, 32'd5, 32'd3, 1'b1, 1'b1, 1'b1);
    step();
    exp_v = {32'hFFFF_FFF9, 1'b0};
    chk("bin_p", {31'd0, out_p}, {31'd0, exp_v});
    exp_v = {32'h0000_0004, 1'b0};
    chk("bin_g", {31'd0, out_g}, {31'd0, exp_v});

    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    step();

    // Back-to-back at full rate.
    for (int i = 0; i < 8; i++) begin
      drive_rand(1'b1, 1'b1);
      step();
      chk("b2b_ready", {63'd0, in_ready}, 64'd1);
      chk("b2b_valid", {63'd0, out_valid}, 64'd1);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    step();

    // Backpressure with X, Y, Z.
    drive(1'b1, 32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_ready_x", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 32'h0000_0033, 32'h0000_0044, 1'b1, 1'b0, 1'b0);
    step();
    chk("bp_ready_y", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 32'h0000_0055, 32'h0000_0066, 1'b0, 1'b1, 1'b0);
    step();
    chk("bp_ready_z", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    z_taken = 1'b0;
    for (int i = 0; i < 6 && !z_taken; i++) begin
      z_taken = (mq.size() < 2);
      step();
    end
    chk("bp_z_taken", {63'd0, z_taken}, 64'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("bp_drained", {63'd0, out_valid}, 64'd0);

    // Reset while holding two beats.
    for (int i = 0; i < 2; i++) begin
      drive_rand(1'b1, 1'b0);
      step();
    end
    chk("two_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_valid", {63'd0, out_valid}, 64'd0);
    chk("rst2_ready", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 1'b1, 1'b0, 1'b0);
    step();
    chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive_rand(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
